// File: rtl/dvi_timing_gen_if.sv
// -----------------------------------------------------------------------------
// dvi_timing_gen_if
//
// Purpose:
//   Pixel-coordinate and sync stream produced by dvi_timing_gen and consumed by
//   the wave display, the note display and the DVI encoder.
//
// Signals:
//   x           [10:0] active column (0 outside the active area)
//   y           [9:0]  active row    (0 outside the active area)
//   valid              current (x, y) is an active pixel
//   hsync              horizontal sync, asserted at the generator's SYNC_POL level
//   vsync              vertical sync, asserted at the generator's SYNC_POL level
//   frame_start        one-cycle pulse accompanying pixel (0,0)
//
// Modports:
//   master  - the timing generator (drives everything)
//   slave   - any consumer of the coordinate stream
// -----------------------------------------------------------------------------
interface dvi_timing_gen_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output x,
        output y,
        output valid,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        input x,
        input y,
        input valid,
        input hsync,
        input vsync,
        input frame_start
    );
endinterface : dvi_timing_gen_if

// File: rtl/dvi_timing_gen.sv
// -----------------------------------------------------------------------------
// dvi_timing_gen
//
// Purpose:
//   Raster timing generator for the 1280x1024 display pipeline. Two free-running
//   counters walk the full frame (active area plus porches and sync). Every
//   output is registered from the counter values present before the advance, so
//   the coordinate stream lags the counters by exactly one enabled cycle.
//
// Ports:
//   clk    in   pixel clock (108 MHz with the default timing)
//   reset  in   asynchronous, active-low reset
//   en     in   advance enable; when low the counters freeze, valid and
//               frame_start drop to 0 and x/y/hsync/vsync hold
//   vid    master modport of dvi_timing_gen_if carrying x, y, valid, hsync,
//               vsync and frame_start
// -----------------------------------------------------------------------------
module dvi_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter int SYNC_POL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    dvi_timing_gen_if.master      vid
);

    // ------------------------------------------------------------------
    // Derived timing constants, all expressed at counter width.
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Asserted and idle sync levels.
    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;

    // Region decode of the current (pre-advance) counter position.
    logic        h_active_s;
    logic        v_active_s;
    logic        active_s;
    logic        hs_window_s;
    logic        vs_window_s;
    logic        origin_s;
    logic        h_wrap_s;
    logic        v_wrap_s;

    // Decode where the counters currently sit within the frame.
    always_comb begin
        h_active_s  = (h_cnt_q < H_ACT_END);
        v_active_s  = (v_cnt_q < V_ACT_END);
        active_s    = h_active_s && v_active_s;
        // hsync depends on h_cnt only, so it keeps running through vertical blanking.
        hs_window_s = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        // vsync covers every pixel of the vsync lines, including their blanking.
        vs_window_s = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        origin_s    = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        h_wrap_s    = (h_cnt_q == H_LAST);
        v_wrap_s    = (v_cnt_q == V_LAST);
    end

    // Next-state for the horizontal and vertical counters.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_wrap_s) begin
                h_cnt_d = 11'd0;
                // The vertical counter only moves on the line wrap, and wraps
                // itself on the same edge when the last line ends.
                if (v_wrap_s) begin
                    v_cnt_d = 11'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 11'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Next-state for the registered coordinate and sync outputs.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        valid_d       = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (en) begin
            valid_d       = active_s;
            // Coordinates read zero during blanking so consumers never see a
            // stale position alongside valid=0.
            x_d           = active_s ? h_cnt_q : 11'd0;
            y_d           = active_s ? v_cnt_q[9:0] : 10'd0;
            hsync_d       = hs_window_s ? SYNC_ON : SYNC_OFF;
            vsync_d       = vs_window_s ? SYNC_ON : SYNC_OFF;
            frame_start_d = origin_s;
        end else begin
            // Paused: no pixel is presented, position and sync levels hold.
            x_d           = x_q;
            y_d           = y_q;
            valid_d       = 1'b0;
            hsync_d       = hsync_q;
            vsync_d       = vsync_q;
            frame_start_d = 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Output registers; reset puts both syncs at their idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q           <= 11'd0;
            y_q           <= 10'd0;
            valid_q       <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.valid       = valid_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.frame_start = frame_start_q;

endmodule : dvi_timing_gen

// File: tb/tb_dvi_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_dvi_timing_gen
//
// Instance A uses the default 1280x1024 timing (SYNC_POL=0).
// Instance B uses a tiny raster (16x9 total, 8x4 active, SYNC_POL=1) so whole
// frames and the vsync window fit in a short run:
//   h: active 0..7, fp 8..9, hsync 10..12, bp 13..15
//   v: active 0..3, fp 4,    vsync 5..6,   bp 7..8
// -----------------------------------------------------------------------------
module tb_dvi_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic en_a;
    logic reset_b;
    logic en_b;

    int n_checks = 0;
    int n_fail   = 0;

    dvi_timing_gen_if vid_a ();
    dvi_timing_gen_if vid_b ();

    dvi_timing_gen u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .en    (en_a),
        .vid   (vid_a)
    );

    dvi_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .SYNC_POL (1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .en    (en_b),
        .vid   (vid_b)
    );

    // One clock: outputs are sampled on the falling edge, away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_a = 1'b0; en_a = 1'b1;
        reset_b = 1'b0; en_b = 1'b0;
        repeat (5) step();
        n_checks++; if (vid_a.x !== 11'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", vid_a.x); end
        n_checks++; if (vid_a.y !== 10'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", vid_a.y); end
        n_checks++; if (vid_a.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", vid_a.valid); end
        n_checks++; if (vid_a.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", vid_a.frame_start); end
        n_checks++; if (vid_a.hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", vid_a.hsync); end
        n_checks++; if (vid_a.vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", vid_a.vsync); end
        reset_a = 1'b1;
        step();
        n_checks++; if (vid_a.frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs got %b want 1", vid_a.frame_start); end
        n_checks++; if (vid_a.valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", vid_a.valid); end
        n_checks++; if (vid_a.x !== 11'd0 || vid_a.y !== 10'd0) begin n_fail++; $display("FAIL first_xy got (%0d,%0d) want (0,0)", vid_a.x, vid_a.y); end
        step();
        n_checks++; if (vid_a.x !== 11'd1) begin n_fail++; $display("FAIL second_x got %0d want 1", vid_a.x); end
        n_checks++; if (vid_a.frame_start !== 1'b0) begin n_fail++; $display("FAIL second_fs got %b want 0", vid_a.frame_start); end
    endtask

    // Rest of line 0 (columns 2..1687), then first pixel of line 1.
    task automatic test_line();
        int valid_cnt = 0;
        int hlow_cnt  = 0;
        int first_low = -1;
        int bad       = 0;
        logic [10:0] exp_x;
        for (int k = 2; k < 1688; k++) begin
            step();
            exp_x = (k < 1280) ? 11'(k) : 11'd0;
            if (vid_a.valid === 1'b1) valid_cnt++;
            if (vid_a.hsync === 1'b0) begin
                if (first_low < 0) first_low = k;
                hlow_cnt++;
            end
            if (vid_a.x !== exp_x) bad++;
            if (vid_a.y !== 10'd0) bad++;
            if (vid_a.vsync !== 1'b1) bad++;
            if (vid_a.frame_start !== 1'b0) bad++;
        end
        // Columns 0 and 1 were already seen in test_reset: 1280 - 2 remain.
        n_checks++; if (valid_cnt != 1278) begin n_fail++; $display("FAIL line_valid_cnt got %0d want 1278", valid_cnt); end
        n_checks++; if (hlow_cnt != 112) begin n_fail++; $display("FAIL line_hsync_cnt got %0d want 112", hlow_cnt); end
        n_checks++; if (first_low != 1328) begin n_fail++; $display("FAIL line_hsync_start got %0d want 1328", first_low); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL line_ramp got %0d bad samples want 0", bad); end
        step();
        n_checks++; if (vid_a.y !== 10'd1 || vid_a.x !== 11'd0 || vid_a.valid !== 1'b1) begin
            n_fail++; $display("FAIL line1_start got (%0d,%0d,v=%b) want (0,1,v=1)", vid_a.x, vid_a.y, vid_a.valid); end
    endtask

    task automatic test_enable();
        int bad = 0;
        // From output (0,1) to output (499,10): 9 lines of 1688 plus 499.
        repeat (15691) step();
        n_checks++; if (vid_a.x !== 11'd499 || vid_a.y !== 10'd10 || vid_a.valid !== 1'b1) begin
            n_fail++; $display("FAIL en_pre got (%0d,%0d,v=%b) want (499,10,v=1)", vid_a.x, vid_a.y, vid_a.valid); end
        en_a = 1'b0;
        #1;
        n_checks++; if (vid_a.valid !== 1'b1) begin n_fail++; $display("FAIL en_comb_path got valid %b want 1", vid_a.valid); end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            step();
            if (vid_a.valid !== 1'b0) bad++;
            if (vid_a.frame_start !== 1'b0) bad++;
            if (vid_a.x !== 11'd499 || vid_a.y !== 10'd10) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL en_hold got %0d bad samples want 0", bad); end
        en_a = 1'b1;
        step();
        n_checks++; if (vid_a.x !== 11'd500 || vid_a.y !== 10'd10 || vid_a.valid !== 1'b1) begin
            n_fail++; $display("FAIL en_resume got (%0d,%0d,v=%b) want (500,10,v=1)", vid_a.x, vid_a.y, vid_a.valid); end
        step();
        n_checks++; if (vid_a.x !== 11'd501) begin n_fail++; $display("FAIL en_resume_next got %0d want 501", vid_a.x); end
    endtask

    // Small raster, active-high syncs, one full frame of 144 cycles.
    task automatic test_sync_pol();
        int valid_cnt = 0;
        int hs_cnt    = 0;
        int vs_cnt    = 0;
        int vs_first  = -1;
        int fs_cnt    = 0;
        logic last_valid = 1'b1;
        n_checks++; if (vid_b.hsync !== 1'b0 || vid_b.vsync !== 1'b0) begin
            n_fail++; $display("FAIL pol_reset_sync got h=%b v=%b want 0 0", vid_b.hsync, vid_b.vsync); end
        n_checks++; if (vid_b.valid !== 1'b0) begin n_fail++; $display("FAIL pol_reset_valid got %b want 0", vid_b.valid); end
        en_b = 1'b1;
        reset_b = 1'b1;
        step();
        n_checks++; if (vid_b.frame_start !== 1'b1 || vid_b.valid !== 1'b1) begin
            n_fail++; $display("FAIL pol_first got fs=%b v=%b want 1 1", vid_b.frame_start, vid_b.valid); end
        for (int j = 1; j < 144; j++) begin
            step();
            if (vid_b.valid === 1'b1) valid_cnt++;
            if (vid_b.hsync === 1'b1) hs_cnt++;
            if (vid_b.vsync === 1'b1) begin
                if (vs_first < 0) vs_first = j;
                vs_cnt++;
            end
            if (vid_b.frame_start === 1'b1) fs_cnt++;
            if (j == 143) last_valid = vid_b.valid;
        end
        n_checks++; if (valid_cnt != 31) begin n_fail++; $display("FAIL pol_valid_cnt got %0d want 31", valid_cnt); end
        n_checks++; if (hs_cnt != 27) begin n_fail++; $display("FAIL pol_hsync_cnt got %0d want 27", hs_cnt); end
        n_checks++; if (vs_cnt != 32) begin n_fail++; $display("FAIL pol_vsync_cnt got %0d want 32", vs_cnt); end
        n_checks++; if (vs_first != 80) begin n_fail++; $display("FAIL pol_vsync_start got %0d want 80", vs_first); end
        n_checks++; if (fs_cnt != 0) begin n_fail++; $display("FAIL pol_fs_extra got %0d want 0", fs_cnt); end
        n_checks++; if (last_valid !== 1'b0) begin n_fail++; $display("FAIL pol_wrap_blank got %b want 0", last_valid); end
        step();
        n_checks++; if (vid_b.frame_start !== 1'b1 || vid_b.x !== 11'd0 || vid_b.y !== 10'd0 || vid_b.valid !== 1'b1) begin
            n_fail++; $display("FAIL pol_frame2 got fs=%b (%0d,%0d) v=%b want fs=1 (0,0) v=1",
                               vid_b.frame_start, vid_b.x, vid_b.y, vid_b.valid); end
    endtask

    task automatic test_async_reset();
        // From frame-2 origin to output (h=5, v=5), inside the vsync window.
        repeat (85) step();
        n_checks++; if (vid_b.vsync !== 1'b1) begin n_fail++; $display("FAIL ar_pre_vsync got %b want 1", vid_b.vsync); end
        #2 reset_b = 1'b0;
        #1;
        n_checks++; if (vid_b.vsync !== 1'b0) begin n_fail++; $display("FAIL ar_vsync_immediate got %b want 0", vid_b.vsync); end
        n_checks++; if (vid_b.hsync !== 1'b0 || vid_b.valid !== 1'b0 || vid_b.x !== 11'd0) begin
            n_fail++; $display("FAIL ar_outputs got h=%b v=%b x=%0d want 0 0 0", vid_b.hsync, vid_b.valid, vid_b.x); end
        @(posedge clk);
        #1;
        n_checks++; if (vid_b.vsync !== 1'b0) begin n_fail++; $display("FAIL ar_vsync_held got %b want 0", vid_b.vsync); end
        #2 reset_b = 1'b1;
        @(negedge clk);
        step();
        n_checks++; if (vid_b.frame_start !== 1'b1 || vid_b.x !== 11'd0 || vid_b.y !== 10'd0 || vid_b.valid !== 1'b1) begin
            n_fail++; $display("FAIL ar_restart got fs=%b (%0d,%0d) v=%b want fs=1 (0,0) v=1",
                               vid_b.frame_start, vid_b.x, vid_b.y, vid_b.valid); end
        step();
        n_checks++; if (vid_b.x !== 11'd1 || vid_b.frame_start !== 1'b0) begin
            n_fail++; $display("FAIL ar_restart_next got x=%0d fs=%b want 1 0", vid_b.x, vid_b.frame_start); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_enable();
        test_sync_pol();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dvi_timing_gen
